// File: rtl/br_predictor.sv
// Branch predictor: direct-mapped BTB plus a table of 2-bit saturating counters,
// indexed bimodally (MODE 0) or gshare-style (MODE 1), trained from decode.
module br_predictor #(
    parameter int width    = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 4,
    parameter int MODE     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IF_valid_i,
    input  logic [width-1:0]    IF_pc_i,
    output logic                IF_pred_taken_o,
    output logic                IF_btb_hit_o,
    output logic [width-1:0]    IF_pred_target_o,
    output logic [GHR_BITS-1:0] IF_ghr_o,
    input  logic                ID_upd_valid_i,
    input  logic [width-1:0]    ID_upd_pc_i,
    input  logic [GHR_BITS-1:0] ID_upd_ghr_i,
    input  logic                ID_upd_is_br_i,
    input  logic                ID_upd_is_jump_i,
    input  logic                ID_upd_taken_i,
    input  logic [width-1:0]    ID_upd_target_i,
    input  logic                ID_upd_mispred_i,
    output logic [31:0]         perf_br_o,
    output logic [31:0]         perf_mispred_o
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [width-1:0] PC_STEP = width'(32'd4);

    typedef logic [IDX_BITS-1:0] idx_t;

    logic                btb_valid_q [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q   [ENTRIES];
    logic [width-1:0]    btb_tgt_q   [ENTRIES];
    logic                btb_jmp_q   [ENTRIES];
    logic [1:0]          ctr_q       [ENTRIES];

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         perf_br_q, perf_br_d;
    logic [31:0]         perf_mis_q, perf_mis_d;

    idx_t                lk_idx_s, lk_cidx_s;
    logic [TAG_BITS-1:0] lk_tag_s;
    logic                lk_hit_s, lk_taken_s;
    logic [width-1:0]    lk_target_s;

    idx_t                up_idx_s, up_cidx_s;
    logic [TAG_BITS-1:0] up_tag_s;
    logic                up_br_s, up_jmp_s, btb_we_s;
    logic [1:0]          ctr_d;
    logic                unused_ok_s;

    function automatic idx_t ctr_index(input idx_t base, input logic [GHR_BITS-1:0] ghr);
        idx_t r;
        if (MODE == 1) begin
            r = base ^ idx_t'(ghr);
        end else begin
            r = base;
        end
        return r;
    endfunction

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        if (up) begin
            if (c != 2'b11) r = c + 2'b01;
            else            r = c;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
            else            r = c;
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v != 32'hFFFF_FFFF) r = v + 32'd1;
        else                    r = v;
        return r;
    endfunction

    // Fetch lookup, purely combinational from registered state (no update bypass)
    always_comb begin
        lk_idx_s   = IF_pc_i[IDX_BITS+1:2];
        lk_tag_s   = IF_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        lk_cidx_s  = ctr_index(lk_idx_s, ghr_q);
        lk_hit_s   = IF_valid_i & btb_valid_q[lk_idx_s] & (btb_tag_q[lk_idx_s] == lk_tag_s);
        lk_taken_s = lk_hit_s & (btb_jmp_q[lk_idx_s] | ctr_q[lk_cidx_s][1]);
        if (lk_taken_s) begin
            lk_target_s = btb_tgt_q[lk_idx_s];
        end else begin
            lk_target_s = IF_pc_i + PC_STEP;
        end
    end

    // Resolution decode and next-state for counters, history and perf counters
    always_comb begin
        up_idx_s   = ID_upd_pc_i[IDX_BITS+1:2];
        up_tag_s   = ID_upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
        up_cidx_s  = ctr_index(up_idx_s, ID_upd_ghr_i);
        up_br_s    = ID_upd_valid_i & ID_upd_is_br_i;
        up_jmp_s   = ID_upd_valid_i & ~ID_upd_is_br_i & ID_upd_is_jump_i;
        btb_we_s   = (up_br_s | up_jmp_s) & ID_upd_taken_i;
        ctr_d      = ctr_step(ctr_q[up_cidx_s], ID_upd_taken_i);
        ghr_d      = ghr_q;
        perf_br_d  = perf_br_q;
        perf_mis_d = perf_mis_q;
        if (up_br_s && (MODE == 1)) begin
            ghr_d = GHR_BITS'({ghr_q, ID_upd_taken_i});
        end else begin
            ghr_d = ghr_q;
        end
        if (up_br_s) begin
            perf_br_d = sat_inc(perf_br_q);
        end else begin
            perf_br_d = perf_br_q;
        end
        // Updates that are neither branch nor jump are no-ops, perf counters included
        if ((up_br_s | up_jmp_s) && ID_upd_mispred_i) begin
            perf_mis_d = sat_inc(perf_mis_q);
        end else begin
            perf_mis_d = perf_mis_q;
        end
    end

    // Valid bits, counters, history and perf counters with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                ctr_q[i]       <= 2'b01;
            end
            ghr_q      <= {GHR_BITS{1'b0}};
            perf_br_q  <= 32'd0;
            perf_mis_q <= 32'd0;
        end else begin
            if (btb_we_s) begin
                btb_valid_q[up_idx_s] <= 1'b1;
            end
            if (up_br_s) begin
                ctr_q[up_cidx_s] <= ctr_d;
            end
            ghr_q      <= ghr_d;
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    // BTB payload is only meaningful behind a set valid bit, so it carries no reset
    always_ff @(posedge clk) begin
        if (rst && btb_we_s) begin
            btb_tag_q[up_idx_s] <= up_tag_s;
            btb_tgt_q[up_idx_s] <= ID_upd_target_i;
            btb_jmp_q[up_idx_s] <= up_jmp_s;
        end
    end

    assign unused_ok_s      = ^ID_upd_pc_i;
    assign IF_btb_hit_o     = lk_hit_s;
    assign IF_pred_taken_o  = lk_taken_s;
    assign IF_pred_target_o = lk_target_s;
    assign IF_ghr_o         = ghr_q;
    assign perf_br_o        = perf_br_q;
    assign perf_mispred_o   = perf_mis_q;

endmodule

// File: tb/tb_br_predictor.sv
// Bench for br_predictor: a bimodal and a gshare instance share stimulus and are
// checked every cycle against an array-based model, plus hand-computed pins.
module tb_br_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [31:0] ipc;
    logic        uv, ubr, ujmp, utk, umis;
    logic [31:0] upc, utgt;
    logic [3:0]  ughr;

    logic        o_hit  [2];
    logic        o_tk   [2];
    logic [31:0] o_tgt  [2];
    logic [3:0]  o_ghr  [2];
    logic [31:0] o_pbr  [2];
    logic [31:0] o_pmis [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: BTB shared by both modes, counters and history per mode
    bit          mv   [64];
    int unsigned mtag [64];
    logic [31:0] mtgt [64];
    bit          mj   [64];
    int          mc   [2][64];
    int unsigned mg   [2];
    logic [31:0] pbr, pmis;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        br_predictor #(
            .width(32), .IDX_BITS(6), .TAG_BITS(8), .GHR_BITS(4), .MODE(g)
        ) u_dut (
            .clk(clk), .rst(rst),
            .IF_valid_i(iv), .IF_pc_i(ipc),
            .IF_pred_taken_o(o_tk[g]), .IF_btb_hit_o(o_hit[g]),
            .IF_pred_target_o(o_tgt[g]), .IF_ghr_o(o_ghr[g]),
            .ID_upd_valid_i(uv), .ID_upd_pc_i(upc), .ID_upd_ghr_i(ughr),
            .ID_upd_is_br_i(ubr), .ID_upd_is_jump_i(ujmp), .ID_upd_taken_i(utk),
            .ID_upd_target_i(utgt), .ID_upd_mispred_i(umis),
            .perf_br_o(o_pbr[g]), .perf_mispred_o(o_pmis[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int unsigned idx, tag, ci;
        bit br, jmp;
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mv[i] = 1'b0; mc[0][i] = 1; mc[1][i] = 1;
            end
            mg[0] = 0; mg[1] = 0; pbr = 32'd0; pmis = 32'd0;
        end else if (uv) begin
            br  = ubr;
            jmp = ujmp && !ubr;
            idx = (upc >> 2) & 63;
            tag = (upc >> 8) & 255;
            if (br) begin
                for (int m = 0; m < 2; m++) begin
                    ci = (m == 1) ? (idx ^ ughr) : idx;
                    if (utk) mc[m][ci] = (mc[m][ci] == 3) ? 3 : mc[m][ci] + 1;
                    else     mc[m][ci] = (mc[m][ci] == 0) ? 0 : mc[m][ci] - 1;
                end
                mg[1] = ((mg[1] << 1) | utk) & 15;
                if (pbr != 32'hFFFF_FFFF) pbr = pbr + 32'd1;
            end
            if ((br || jmp) && utk) begin
                mv[idx] = 1'b1; mtag[idx] = tag; mtgt[idx] = utgt; mj[idx] = jmp;
            end
            if ((br || jmp) && umis && pmis != 32'hFFFF_FFFF) pmis = pmis + 32'd1;
        end
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                int unsigned idx, tag, ci;
                bit e_hit, e_tk;
                logic [31:0] e_tgt;
                idx   = (ipc >> 2) & 63;
                tag   = (ipc >> 8) & 255;
                ci    = (m == 1) ? (idx ^ mg[1]) : idx;
                e_hit = iv && mv[idx] && (mtag[idx] == tag);
                e_tk  = e_hit && (mj[idx] || mc[m][ci] >= 2);
                e_tgt = e_tk ? mtgt[idx] : ipc + 32'd4;
                chk($sformatf("d%0d.hit", m),    32'(o_hit[m]), 32'(e_hit));
                chk($sformatf("d%0d.taken", m),  32'(o_tk[m]),  32'(e_tk));
                chk($sformatf("d%0d.target", m), o_tgt[m],      e_tgt);
                chk($sformatf("d%0d.ghr", m),    32'(o_ghr[m]), mg[m]);
                chk($sformatf("d%0d.perf_br", m),  o_pbr[m],  pbr);
                chk($sformatf("d%0d.perf_mis", m), o_pmis[m], pmis);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit u, input logic [31:0] up,
                         input logic [3:0] g, input bit b, input bit j, input bit t,
                         input logic [31:0] tg, input bit ms);
        iv = v; ipc = pc; uv = u; upc = up; ughr = g;
        ubr = b; ujmp = j; utk = t; utgt = tg; umis = ms;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [3:0] g, input bit b, input bit j,
                       input bit t, input logic [31:0] tg, input bit ms);
        drive(1'b1, pc, 1'b1, pc, g, b, j, t, tg, ms);
        #1;
    endtask

    task automatic look(input bit v, input logic [31:0] pc);
        drive(v, pc, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        look(1'b0, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;

        look(1'b1, 32'h100);
        chk("rst.hit", 32'(o_hit[0]), 32'd0);
        chk("rst.taken", 32'(o_tk[0]), 32'd0);
        chk("rst.target", o_tgt[0], 32'h104);
        chk("rst.perf_br", o_pbr[0], 32'd0);
        tick();

        upd(32'h100, 4'd0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("first.pre_hit", 32'(o_hit[0]), 32'd0);
        tick();
        look(1'b1, 32'h100);
        chk("first.hit", 32'(o_hit[0]), 32'd1);
        chk("first.taken", 32'(o_tk[0]), 32'd1);
        chk("first.target", o_tgt[0], 32'h80);
        chk("first.perf_br", o_pbr[0], 32'd1);
        tick();

        repeat (3) begin
            upd(32'h100, 4'd0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
            tick();
        end
        upd(32'h100, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        look(1'b1, 32'h100);
        chk("sat.n1_taken", 32'(o_tk[0]), 32'd1);
        chk("sat.n1_target", o_tgt[0], 32'h80);
        tick();
        upd(32'h100, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        look(1'b1, 32'h100);
        chk("sat.n2_taken", 32'(o_tk[0]), 32'd0);
        chk("sat.n2_hit", 32'(o_hit[0]), 32'd1);
        chk("sat.n2_target", o_tgt[0], 32'h104);
        tick();

        look(1'b1, 32'h200);
        chk("alias.hit", 32'(o_hit[0]), 32'd0);
        chk("alias.target", o_tgt[0], 32'h204);
        tick();

        upd(32'h40, 4'd0, 1'b0, 1'b1, 1'b1, 32'h1000, 1'b0);
        tick();
        look(1'b1, 32'h40);
        chk("jal.taken", 32'(o_tk[0]), 32'd1);
        chk("jal.target", o_tgt[0], 32'h1000);
        chk("jal.perf_br", o_pbr[0], 32'd6);
        chk("jal.ghr0", 32'(o_ghr[0]), 32'd0);
        chk("jal.ghr1", 32'(o_ghr[1]), 32'hC);
        tick();

        upd(32'h100, 4'd0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("same.old_hit", 32'(o_hit[0]), 32'd1);
        chk("same.old_taken", 32'(o_tk[0]), 32'd0);
        chk("same.old_target", o_tgt[0], 32'h104);
        tick();
        look(1'b1, 32'h100);
        chk("same.new_taken", 32'(o_tk[0]), 32'd1);
        chk("same.new_target", o_tgt[0], 32'h80);
        chk("same.perf_br", o_pbr[0], 32'd7);
        tick();

        look(1'b0, 32'h100);
        chk("novalid.hit", 32'(o_hit[0]), 32'd0);
        chk("novalid.taken", 32'(o_tk[0]), 32'd0);
        chk("novalid.target", o_tgt[0], 32'h104);
        tick();
        look(1'b1, 32'hFFFF_FFFC);
        chk("wrap.target", o_tgt[0], 32'h0);
        tick();

        // Gshare: history built from T,N,T, then counter trained under history 0101
        do_reset();
        upd(32'h10, 4'd0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0); tick();
        upd(32'h10, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);   tick();
        upd(32'h10, 4'd0, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0); tick();
        look(1'b1, 32'h0);
        chk("gs.ghr1", 32'(o_ghr[1]), 32'h5);
        chk("gs.ghr0", 32'(o_ghr[0]), 32'h0);
        tick();
        upd(32'h100, 4'b0101, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0); tick();
        for (int k = 0; k < 4; k++) begin
            upd(32'h10, 4'd0, 1'b1, 1'b0, (k % 2 == 1), 32'h500, 1'b0);
            tick();
        end
        look(1'b1, 32'h100);
        chk("gs.hist_ghr", 32'(o_ghr[1]), 32'h5);
        chk("gs.hist_taken", 32'(o_tk[1]), 32'd1);
        chk("gs.hist_target", o_tgt[1], 32'h80);
        tick();
        repeat (4) begin
            upd(32'h10, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
        end
        look(1'b1, 32'h100);
        chk("gs.zero_ghr", 32'(o_ghr[1]), 32'h0);
        chk("gs.zero_hit", 32'(o_hit[1]), 32'd1);
        chk("gs.zero_taken", 32'(o_tk[1]), 32'd0);
        chk("gs.zero_target", o_tgt[1], 32'h104);
        tick();
        upd(32'h10, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1); tick();
        look(1'b1, 32'h10);
        chk("gs.mispred1", o_pmis[1], 32'd1);
        chk("gs.mispred0", o_pmis[0], 32'd1);
        tick();

        // Randomised traffic with occasional mid-training resets
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] lpc, rpc;
            logic [15:0] hi;
            int sel;
            bit b, j;
            rst = ($urandom_range(0, 299) != 0);
            hi  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'h0000;
            lpc = {hi, 6'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            rpc = {16'h0000, 6'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 49) == 0) lpc = 32'hFFFF_FFFC;
            sel = $urandom_range(0, 19);
            b = (sel < 9) || (sel == 13);
            j = (sel >= 9 && sel < 14);
            drive(($urandom_range(0, 4) != 0), lpc, ($urandom_range(0, 9) < 7), rpc,
                  4'($urandom_range(0, 15)), b, j, 1'($urandom_range(0, 1)),
                  $urandom, (b || j) && ($urandom_range(0, 3) == 0));
            tick();
        end
        rst = 1'b1;
        look(1'b1, 32'h100);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/br_predictor.md
# br_predictor

Parametrised branch predictor that supplies the fetch-stage prediction consumed by the decode stage's prediction comparator. It is trained by the branch resolution performed in decode. It combines a direct-mapped branch target buffer (BTB) with a table of 2-bit saturating counters. The counter table is indexed either bimodally or gshare-style. It returns a ready-to-use next-PC target and the global-history snapshot that travels down the pipeline with each instruction.

## Interface
Parameters:
- width, 32, address/data width
- IDX_BITS, 6, log2 of the BTB and counter-table entry count
- TAG_BITS, 8, BTB tag width
- GHR_BITS, 4, global history length; must satisfy 1 ≤ GHR_BITS ≤ IDX_BITS
- MODE, 0, 0 = bimodal, 1 = gshare

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset; synchronous, active-low
- IF_valid_i  in  1  fetch lookup valid
- IF_pc_i  in  width  fetch PC
- IF_pred_taken_o  out  1  prediction: taken
- IF_btb_hit_o  out  1  BTB tag match on IF_pc_i
- IF_pred_target_o  out  width  predicted next PC
- IF_ghr_o  out  GHR_BITS  current history, carried down the pipeline with the instruction
- ID_upd_valid_i  in  1  resolution valid, one pulse per instruction
- ID_upd_pc_i  in  width  PC of the resolved instruction
- ID_upd_ghr_i  in  GHR_BITS  IF_ghr_o snapshot returned with the instruction
- ID_upd_is_br_i  in  1  conditional branch
- ID_upd_is_jump_i  in  1  jal/jalr
- ID_upd_taken_i  in  1  resolved taken
- ID_upd_target_i  in  width  resolved target
- ID_upd_mispred_i  in  1  decode raised a flush for this instruction
- perf_br_o  out  32  count of conditional-branch updates
- perf_mispred_o  out  32  count of mispredict updates

## Operation
- **Index and tag:**
  - BTB index = pc[IDX_BITS+1:2].
  - Tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- **Counter index:**
  - MODE 0: same as the BTB index.
  - MODE 1: BTB index XOR {zero-extend, ghr}; ghr is XORed into the low GHR_BITS.
  - Lookups use the current GHR. Updates use ID_upd_ghr_i, never the live GHR.
- **BTB entry fields:** valid, tag, target, is_jump.
- **Lookup (combinational from state):**
  - hit = IF_valid_i & entry.valid & tag match.
  - IF_pred_taken_o = hit & (entry.is_jump | counter[1]).
  - IF_pred_target_o = entry.target when predicted taken, else IF_pc_i + 4 (mod 2^width).
- **Update, when ID_upd_valid_i is high:**
  - If is_br: the counter saturates up toward 2'b11 when taken, down toward 2'b00 when not taken.
  - If is_br: GHR <= {GHR[GHR_BITS-2:0], taken}. In MODE 0 the GHR stays 0.
  - If (is_br | is_jump) & taken: write the BTB entry with valid = 1, the tag, the target and is_jump. An existing entry is overwritten (replaces on alias).
  - A not-taken branch never allocates a BTB entry or invalidates an existing one.
  - Jumps never touch the counters or the GHR.
  - is_br and is_jump both high is illegal; is_br takes precedence.
  - ID_upd_valid_i with neither is_br nor is_jump set leaves all state unchanged.
- **Performance counters:**
  - perf_br_o increments on each is_br update.
  - perf_mispred_o increments on each update with mispred set.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- Lookup latency is 0 cycles, combinational from registered state. An update becomes visible on the cycle after its clock edge.
- A lookup and an update to the same entry in the same cycle: the lookup returns the pre-update contents. There is no bypass.
- **Reset (rst low at a clock edge):**
  - All BTB valid bits, the GHR and both perf counters clear to 0.
  - All counters load 2'b01 (weakly not-taken).
  - Any update presented in the reset cycle is discarded.
- **Outputs after reset:**
  - IF_btb_hit_o = 0 and IF_pred_taken_o = 0.
  - IF_pred_target_o = IF_pc_i + 4.
  - IF_ghr_o = 0, perf_br_o = 0, perf_mispred_o = 0.
- Reset asserted mid-training: all learned state is lost on that edge.
- IF_valid_i = 0 forces IF_btb_hit_o = 0 and IF_pred_taken_o = 0. IF_pred_target_o is then IF_pc_i + 4.

## Test plan
Defaults: MODE 0, IDX_BITS 6, TAG_BITS 8, GHR_BITS 4.

- **Reset:** hold rst low for 1 cycle, then look up 0x100 -> hit 0, taken 0, target 0x104, perf_br_o 0.
- **First taken branch:** one taken is_br update at 0x100 with target 0x80 -> the next-cycle lookup of 0x100 gives hit 1, taken 1, target 0x80, perf_br_o 1.
- **Counter saturation:**
  - Apply 3 more taken updates at 0x100 (counter 11).
  - One not-taken update -> still taken, target 0x80.
  - A second not-taken update -> taken 0, hit 1, target 0x104.
- **Aliasing and jumps:**
  - With the 0x100 entry valid, look up 0x200 (same index, tag 0x02 vs 0x01) -> hit 0, target 0x204.
  - A jal update at 0x40 with target 0x1000 -> lookup of 0x40 gives taken 1, target 0x1000. The GHR and perf_br_o are unchanged.
- **Same-cycle lookup and update:** update and look up 0x100 in the same cycle -> the lookup shows old values and the new values appear the next cycle.
- **MODE 1 (gshare):**
  - Branch updates T, N, T (each carrying ghr snapshot 0) -> IF_ghr_o = 4'b0101.
  - Training 0x100 taken with snapshot 4'b0101 -> a lookup of 0x100 with GHR 0101 predicts taken, while a lookup with GHR 0000 does not.
  - A mispred update increments perf_mispred_o.
